// File: rtl/ctrl_pkg.sv
// Shared control encodings: FSM states, instruction classes, opcodes, PC selects.
// No logic of its own; constants and one legality helper.
// Imported by the sequencer, its interface users and the control decoder.
package ctrl_pkg;

  // Sequencer states (debug-visible, fixed encoding)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  // Instruction classes as carried in the IR
  typedef enum logic [1:0] {
    IT_R = 2'b00,
    IT_I = 2'b01,
    IT_J = 2'b10,
    IT_S = 2'b11
  } itype_e;

  // PC source select
  typedef enum logic [1:0] {
    PC_INC    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_src_e;

  // R-type opcodes
  localparam logic [4:0] OP_AND  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_CMP  = 5'd3;
  // I-type opcodes
  localparam logic [4:0] OP_ANDI = 5'd0;
  localparam logic [4:0] OP_ADDI = 5'd1;
  localparam logic [4:0] OP_LW   = 5'd2;
  localparam logic [4:0] OP_SW   = 5'd3;
  localparam logic [4:0] OP_BEQ  = 5'd4;
  // S-type (shift) opcodes
  localparam logic [4:0] OP_SLL  = 5'd0;
  localparam logic [4:0] OP_SRL  = 5'd1;
  localparam logic [4:0] OP_SRA  = 5'd2;
  localparam logic [4:0] OP_ROT  = 5'd3;
  // J-type opcodes
  localparam logic [4:0] OP_JMP  = 5'd0;
  localparam logic [4:0] OP_CALL = 5'd1;
  localparam logic [4:0] OP_RET  = 5'd2;

  // Each class uses a dense opcode range starting at zero
  function automatic logic is_legal(input logic [1:0] itype, input logic [4:0] op);
    logic ok;
    case (itype)
      IT_R:    ok = (op <= OP_CMP);
      IT_I:    ok = (op <= OP_BEQ);
      IT_J:    ok = (op <= OP_RET);
      default: ok = (op <= OP_ROT);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Bundle of decoded-instruction inputs, memory handshakes and control strobes.
// Pure wiring; no latency.
// Memory readiness flows in on imem_ready/dmem_ready; requests are held until then.
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       instr_type;
  logic [4:0]       opcode;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_wr;
  logic             pc_wr;
  logic [1:0]       pc_src;
  logic             ra_wr;
  logic             rf_wr;
  logic [2:0]       state;
  logic             retire;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal_instr;
  logic             bus_error;

  // Sequencer side
  modport master (
    input  instr_type, opcode, zero, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_wr, pc_wr, pc_src, ra_wr, rf_wr,
           state, retire, instr_cnt, illegal_instr, bus_error
  );

  // Datapath / memory side
  modport slave (
    output instr_type, opcode, zero, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_wr, pc_wr, pc_src, ra_wr, rf_wr,
           state, retire, instr_cnt, illegal_instr, bus_error
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter shared by the FETCH and MEM request phases.
// o_expire is combinational from the count; count updates one cycle after i_en.
// Saturates at TIMEOUT so a stalled request cannot wrap back to "not expired".
module seq_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam int              W        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]    LP_LIMIT = W'(TIMEOUT);

  logic [W-1:0] r_cnt;

  // Count wait cycles; clear has priority, hold at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LP_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LP_LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with retire counter and bus timeout.
// Strobes are combinational from state and inputs; state advances on the next clk edge.
// Holds imem_req/dmem_req until ready; gives up after TIMEOUT wait cycles and flags bus_error.
module multicycle_sequencer
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  multicycle_sequencer_if.master bus
);

  logic [2:0]       r_state;
  logic             r_run;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             r_bus_err;

  logic [2:0] w_state_nxt;
  logic       w_act;
  logic       w_expire;
  logic       w_wait;
  logic       w_timeout;
  logic       w_clr;
  logic       w_imem_req;
  logic       w_dmem_req;
  logic       w_dmem_we;
  logic       w_ir_wr;
  logic       w_pc_wr;
  logic [1:0] w_pc_src;
  logic       w_ra_wr;
  logic       w_rf_wr;
  logic       w_retire;
  logic       w_illegal;

  logic w_is_r, w_is_i, w_is_j, w_legal;
  logic w_is_beq, w_is_cmp, w_is_lw, w_is_sw;

  assign w_is_r   = (bus.instr_type == IT_R);
  assign w_is_i   = (bus.instr_type == IT_I);
  assign w_is_j   = (bus.instr_type == IT_J);
  assign w_legal  = is_legal(bus.instr_type, bus.opcode);
  assign w_is_beq = w_is_i && (bus.opcode == OP_BEQ);
  assign w_is_cmp = w_is_r && (bus.opcode == OP_CMP);
  assign w_is_lw  = w_is_i && (bus.opcode == OP_LW);
  assign w_is_sw  = w_is_i && (bus.opcode == OP_SW);

  // The first cycle after reset release is quiet so the first fetch starts
  // only after rst_n has actually been sampled high; rst_n low masks at once.
  assign w_act = rst_n & r_run;

  // Next-state and per-cycle strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_wait      = 1'b0;
    w_timeout   = 1'b0;
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_ir_wr     = 1'b0;
    w_pc_wr     = 1'b0;
    w_pc_src    = PC_INC;
    w_ra_wr     = 1'b0;
    w_rf_wr     = 1'b0;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        // IR contents are stale here and deliberately not looked at
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_wr     = 1'b1;
          w_pc_wr     = 1'b1;
          w_state_nxt = ST_DECODE;
        end else if (w_expire) begin
          w_timeout = 1'b1;
        end else begin
          w_wait = 1'b1;
        end
      end
      ST_DECODE: begin
        if (!w_legal) begin
          // Undefined encodings retire as a NOP
          w_illegal   = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (w_is_j) begin
          w_pc_wr     = 1'b1;
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
          case (bus.opcode)
            OP_JMP:  w_pc_src = PC_JUMP;
            OP_CALL: begin
              w_pc_src = PC_JUMP;
              w_ra_wr  = 1'b1;
            end
            default: w_pc_src = PC_RET;
          endcase
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_is_beq) begin
          w_pc_wr     = bus.zero;
          w_pc_src    = bus.zero ? PC_BRANCH : PC_INC;
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (w_is_cmp) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          w_state_nxt = ST_MEM;
        end else begin
          w_state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = w_is_sw;
        if (bus.dmem_ready) begin
          // Ready on the expiry cycle still completes normally
          if (w_is_sw) begin
            w_retire    = 1'b1;
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_WB;
          end
        end else if (w_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else begin
          w_wait = 1'b1;
        end
      end
      ST_WB: begin
        w_rf_wr     = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Any state change or a timeout restarts the wait count for the next phase
  assign w_clr = w_act & ((w_state_nxt != r_state) | w_timeout);

  seq_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_wait & w_act),
    .o_expire (w_expire)
  );

  // State register and post-reset run qualifier
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_state <= w_state_nxt;
      end
    end
  end

  // Retired-instruction counter (wraps) and sticky bus error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_instr_cnt <= '0;
      r_bus_err   <= 1'b0;
    end else if (r_run) begin
      if (w_retire) begin
        r_instr_cnt <= r_instr_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign bus.imem_req      = w_imem_req & w_act;
  assign bus.dmem_req      = w_dmem_req & w_act;
  assign bus.dmem_we       = w_dmem_we  & w_act;
  assign bus.ir_wr         = w_ir_wr    & w_act;
  assign bus.pc_wr         = w_pc_wr    & w_act;
  assign bus.pc_src        = w_act ? w_pc_src : PC_INC;
  assign bus.ra_wr         = w_ra_wr    & w_act;
  assign bus.rf_wr         = w_rf_wr    & w_act;
  assign bus.retire        = w_retire   & w_act;
  assign bus.illegal_instr = w_illegal  & w_act;
  assign bus.state         = r_state;
  assign bus.instr_cnt     = r_instr_cnt;
  assign bus.bus_error     = r_bus_err;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle expected traces are queued
// with their stimulus, the DUT outputs are captured each cycle and compared in order.
// Small CNT_W and TIMEOUT keep wrap and timeout scenarios short.
module tb_multicycle_sequencer;
  import ctrl_pkg::*;

  localparam int CNT_W = 8;
  localparam int TO    = 4;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic       ra_wr;
    logic       rf_wr;
    logic       retire;
    logic       illegal;
  } out_t;

  typedef struct packed {
    logic [1:0] t;
    logic [4:0] op;
    logic       z;
    logic       irdy;
    logic       drdy;
    logic       rnd;
  } in_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(CNT_W)) bus ();

  multicycle_sequencer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  in_t  stim_q[$];
  out_t exp_q[$];
  out_t obs_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  function automatic out_t sample();
    out_t o;
    o.st       = bus.state;
    o.imem_req = bus.imem_req;
    o.dmem_req = bus.dmem_req;
    o.dmem_we  = bus.dmem_we;
    o.ir_wr    = bus.ir_wr;
    o.pc_wr    = bus.pc_wr;
    o.pc_src   = bus.pc_src;
    o.ra_wr    = bus.ra_wr;
    o.rf_wr    = bus.rf_wr;
    o.retire   = bus.retire;
    o.illegal  = bus.illegal_instr;
    return o;
  endfunction

  task automatic idle_inputs();
    bus.instr_type = 2'b00;
    bus.opcode     = 5'd0;
    bus.zero       = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
  endtask

  // Reference model: expected per-cycle outputs for one instruction.
  // iw/dw = wait cycles before ready; dw < 0 means dmem_ready never comes.
  task automatic gen(input logic [1:0] t, input logic [4:0] op, input logic z,
                     input int iw, input int dw);
    in_t  s;
    out_t o;
    bit   legal;
    for (int k = 0; k <= iw; k++) begin
      s = '0; s.rnd = 1'b1; s.irdy = (k == iw);
      o = '0; o.st = 3'd0; o.imem_req = 1'b1;
      if (k == iw) begin o.ir_wr = 1'b1; o.pc_wr = 1'b1; end
      stim_q.push_back(s); exp_q.push_back(o);
    end
    s = '0; s.t = t; s.op = op; s.z = z;
    legal = (t == 2'b00 && op <= 5'd3) || (t == 2'b01 && op <= 5'd4) ||
            (t == 2'b10 && op <= 5'd2) || (t == 2'b11 && op <= 5'd3);
    o = '0; o.st = 3'd1;
    if (!legal) begin
      o.illegal = 1'b1; o.retire = 1'b1;
    end else if (t == 2'b10) begin
      o.pc_wr = 1'b1; o.retire = 1'b1; o.ra_wr = (op == 5'd1);
      o.pc_src = (op == 5'd2) ? 2'b11 : 2'b10;
    end
    stim_q.push_back(s); exp_q.push_back(o);
    if (o.retire) begin exp_cnt++; return; end
    o = '0; o.st = 3'd2;
    if (t == 2'b01 && op == 5'd4) begin
      o.pc_wr = z; o.pc_src = z ? 2'b01 : 2'b00; o.retire = 1'b1;
    end else if (t == 2'b00 && op == 5'd3) begin
      o.retire = 1'b1;
    end
    stim_q.push_back(s); exp_q.push_back(o);
    if (o.retire) begin exp_cnt++; return; end
    if (t == 2'b01 && (op == 5'd2 || op == 5'd3)) begin
      for (int k = 0; k <= ((dw < 0) ? TO : dw); k++) begin
        s.drdy = (k == dw);
        o = '0; o.st = 3'd3; o.dmem_req = 1'b1; o.dmem_we = (op == 5'd3);
        o.retire = (k == dw) && (op == 5'd3);
        stim_q.push_back(s); exp_q.push_back(o);
      end
      if (dw < 0) return;
      if (op == 5'd3) begin exp_cnt++; return; end
    end
    s.drdy = 1'b0;
    o = '0; o.st = 3'd4; o.rf_wr = 1'b1; o.retire = 1'b1;
    stim_q.push_back(s); exp_q.push_back(o);
    exp_cnt++;
  endtask

  // Drive queued stimulus one cycle at a time and capture the DUT outputs
  task automatic run_trace();
    in_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      if (s.rnd) begin
        bus.instr_type = 2'($urandom_range(3));
        bus.opcode     = 5'($urandom_range(31));
        bus.zero       = 1'($urandom_range(1));
      end else begin
        bus.instr_type = s.t;
        bus.opcode     = s.op;
        bus.zero       = s.z;
      end
      bus.imem_ready = s.irdy;
      bus.dmem_ready = s.drdy;
      @(negedge clk);
      obs_q.push_back(sample());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", bus.state); end
    n_chk++; if (bus.instr_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.instr_cnt); end
    n_chk++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL reset_buserr got %b want 0", bus.bus_error); end
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req got %b want 0", bus.imem_req); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL release_imem_req got %b want 0", bus.imem_req); end
    @(posedge clk); #1;
    exp_cnt = '0;
  endtask

  task automatic test_alu();
    out_t e, o;
    gen(IT_R, OP_ADD, 1'b0, 0, 0);
    gen(IT_R, OP_SUB, 1'b1, 0, 0);
    gen(IT_R, OP_AND, 1'b0, 0, 0);
    gen(IT_I, OP_ANDI, 1'b0, 0, 0);
    gen(IT_I, OP_ADDI, 1'b1, 0, 0);
    gen(IT_S, OP_SLL, 1'b0, 0, 0);
    gen(IT_S, OP_ROT, 1'b0, 0, 0);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL alu cyc %0d got %h want %h", i, o, e); end
    end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL alu_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_wait();
    out_t e, o;
    gen(IT_R, OP_ADD, 1'b0, 2, 0);
    gen(IT_J, OP_JMP, 1'b0, 1, 0);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL fetch_wait cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_lw_wait();
    out_t e, o;
    int nreq = 0;
    int ret_at = -1;
    gen(IT_I, OP_LW, 1'b0, 0, 3);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL lw cyc %0d got %h want %h", i, o, e); end
      if (o.dmem_req) nreq++;
      if (o.retire && ret_at < 0) ret_at = i + 1;
    end
    n_chk++; if (nreq != 4) begin n_fail++; $display("FAIL lw_req_cycles got %0d want 4", nreq); end
    n_chk++; if (ret_at != 8) begin n_fail++; $display("FAIL lw_total_cycles got %0d want 8", ret_at); end
  endtask

  task automatic test_sw_beq_cmp();
    out_t e, o;
    gen(IT_I, OP_SW, 1'b0, 0, 0);
    gen(IT_I, OP_SW, 1'b0, 1, 2);
    gen(IT_I, OP_BEQ, 1'b1, 0, 0);
    gen(IT_I, OP_BEQ, 1'b0, 0, 0);
    gen(IT_R, OP_CMP, 1'b1, 0, 0);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL sw_beq_cmp cyc %0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_jumps_illegal();
    out_t e, o;
    int nill = 0;
    gen(IT_J, OP_JMP, 1'b0, 0, 0);
    gen(IT_J, OP_CALL, 1'b0, 0, 0);
    gen(IT_J, OP_RET, 1'b0, 0, 0);
    gen(IT_J, 5'd7, 1'b0, 0, 0);
    gen(IT_R, 5'd4, 1'b0, 0, 0);
    gen(IT_I, 5'd5, 1'b0, 0, 0);
    gen(IT_S, 5'd31, 1'b0, 0, 0);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL jumps cyc %0d got %h want %h", i, o, e); end
      if (o.illegal) nill++;
    end
    n_chk++; if (nill != 4) begin n_fail++; $display("FAIL illegal_pulses got %0d want 4", nill); end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL jumps_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_ready_on_timeout();
    out_t e, o;
    gen(IT_I, OP_LW, 1'b0, 0, TO);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL ready_at_limit cyc %0d got %h want %h", i, o, e); end
    end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL ready_at_limit_buserr got %b want 0", bus.bus_error); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    out_t e, o;
    gen(IT_I, OP_SW, 1'b0, 0, -1);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL timeout cyc %0d got %h want %h", i, o, e); end
    end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.bus_error !== 1'b1) begin n_fail++; $display("FAIL timeout_buserr got %b want 1", bus.bus_error); end
    n_chk++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL timeout_state got %0d want 0", bus.state); end
    n_chk++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL timeout_dmem_req got %b want 0", bus.dmem_req); end
    n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL timeout_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mem();
    out_t e, o;
    gen(IT_I, OP_LW, 1'b0, 0, -1);
    repeat (3) begin void'(stim_q.pop_back()); void'(exp_q.pop_back()); end
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mid_mem cyc %0d got %h want %h", i, o, e); end
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL mid_mem_state got %0d want 3", bus.state); end
    n_chk++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL mid_mem_req_in_reset got %b want 0", bus.dmem_req); end
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", bus.state); end
    n_chk++; if (bus.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_dmem_req got %b want 0", bus.dmem_req); end
    n_chk++; if (bus.instr_cnt !== '0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", bus.instr_cnt); end
    n_chk++; if (bus.bus_error !== 1'b0) begin n_fail++; $display("FAIL rst_buserr got %b want 0", bus.bus_error); end
    exp_cnt = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    out_t e, o;
    while (exp_cnt != {CNT_W{1'b1}}) gen(IT_J, OP_JMP, 1'b0, 0, 0);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_fill cyc %0d got %h want %h", i, o, e); end
    end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.instr_cnt !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL wrap_full got %h want all-ones", bus.instr_cnt); end
    @(posedge clk); #1;
    gen(IT_J, OP_CALL, 1'b0, 0, 0);
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_last cyc %0d got %h want %h", i, o, e); end
    end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.instr_cnt !== '0) begin n_fail++; $display("FAIL wrap_zero got %h want 0", bus.instr_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    out_t e, o;
    logic [1:0] t;
    for (int n = 0; n < 12; n++) begin
      t = 2'($urandom_range(3));
      gen(t, 5'($urandom_range(5)), 1'($urandom_range(1)),
          $urandom_range(1), $urandom_range(2));
    end
    run_trace();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL b2b cyc %0d got %h want %h", i, o, e); end
    end
    idle_inputs();
    @(negedge clk);
    n_chk++; if (bus.instr_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got %0d want %0d", bus.instr_cnt, exp_cnt); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_fetch_wait();
    test_lw_wait();
    test_sw_beq_cmp();
    test_jumps_illegal();
    test_ready_on_timeout();
    test_timeout();
    test_reset_mid_mem();
    test_wrap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
